de_pipe_reg: RTL and testbench

DE_PIPE_REG -- requirements
Module: de_pipe_reg

---
 rtl/de_pipe_reg_pkg.sv | 54 +++++
 rtl/de_pipe_reg_if.sv | 30 +++
 rtl/de_hazard.sv | 21 ++
 rtl/de_pipe_reg.sv | 124 ++++++++++++
 tb/tb_de_pipe_reg.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/de_pipe_reg_pkg.sv
// Shared definitions for the decode->execute pipeline register.
// XLEN defaults to 32 unless `XLEN is defined before this file is read.
`ifndef XLEN
`define XLEN 32
`endif

package de_pipe_reg_pkg;

  localparam int XLEN_DEF = `XLEN;
  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 4;
  localparam int CNT_W    = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_LUI  = 4'hA
  } alu_op_e;

  // Control part of an E entry; data fields of a bubble are all zero.
  typedef struct packed {
    logic                valid;
    logic                need_dstE;
    logic                sel_reg;
    logic [REG_W-1:0]    dstE;
    logic [ALU_OP_W-1:0] alu_op;
  } e_ctrl_t;

  // sel_reg=1 marks "not a load" so a bubble can never create a load-use hazard.
  localparam e_ctrl_t E_CTRL_BUBBLE = '{
    valid:     1'b0,
    need_dstE: 1'b0,
    sel_reg:   1'b1,
    dstE:      '0,
    alu_op:    ALU_ADD
  };

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// Hazard bundle: decode-side source use, execute-side destination, and
// the resulting stall/flush controls.
interface de_pipe_reg_if;
  import de_pipe_reg_pkg::*;

  logic             d_valid;
  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic             d_use_rs1;
  logic             d_use_rs2;
  logic             e_valid;
  logic             e_need_dstE;
  logic             e_sel_reg;
  logic [REG_W-1:0] e_dstE;
  logic             redirect;
  logic             stall;
  logic             flush;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    output e_valid, e_need_dstE, e_sel_reg, e_dstE, redirect,
    input  stall, flush
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
    input  e_valid, e_need_dstE, e_sel_reg, e_dstE, redirect,
    output stall, flush
  );
endinterface

// File: rtl/de_hazard.sv
// Combinational load-use / redirect hazard detection.
module de_hazard
  import de_pipe_reg_pkg::*;
(
  de_pipe_reg_if.slave hz
);

  logic w_src_match;
  logic w_load_use;

  // A load in E whose rd (never x0) feeds a source D actually reads.
  assign w_src_match = (hz.d_use_rs1 && (hz.d_rs1 == hz.e_dstE)) ||
                       (hz.d_use_rs2 && (hz.d_rs2 == hz.e_dstE));
  assign w_load_use  = hz.e_valid && hz.e_need_dstE && !hz.e_sel_reg &&
                       hz.d_valid && (hz.e_dstE != '0) && w_src_match;

  // Redirect squashes D anyway, so it overrides the stall.
  assign hz.stall = w_load_use && !hz.redirect;
  assign hz.flush = hz.redirect;

endmodule

// File: rtl/de_pipe_reg.sv
// Decode->execute pipeline register with load-use stall, redirect flush
// and optional performance counters (macro DE_PERF_CNT_EN).
module de_pipe_reg
  import de_pipe_reg_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                D_valid_i,
  input  logic [XLEN-1:0]     D_pc_i,
  input  logic [XLEN-1:0]     D_fwdA_i,
  input  logic [XLEN-1:0]     D_fwdB_i,
  input  logic [XLEN-1:0]     D_imm_i,
  input  logic [REG_W-1:0]    D_rs1_i,
  input  logic [REG_W-1:0]    D_rs2_i,
  input  logic [REG_W-1:0]    D_dstE_i,
  input  logic                D_use_rs1_i,
  input  logic                D_use_rs2_i,
  input  logic                D_need_dstE_i,
  input  logic                D_sel_reg_i,
  input  logic [ALU_OP_W-1:0] D_alu_op_i,
  input  logic                E_redirect_i,
  output logic                E_valid_o,
  output logic [XLEN-1:0]     E_pc_o,
  output logic [XLEN-1:0]     E_srcA_o,
  output logic [XLEN-1:0]     E_srcB_o,
  output logic [XLEN-1:0]     E_imm_o,
  output logic [REG_W-1:0]    E_dstE_o,
  output logic                E_need_dstE_o,
  output logic                E_sel_reg_o,
  output logic [ALU_OP_W-1:0] E_alu_op_o,
  output logic                F_stall_o,
  output logic                D_stall_o,
  output logic                D_flush_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  e_ctrl_t         r_ctrl;
  logic [XLEN-1:0] r_pc, r_srcA, r_srcB, r_imm;
  logic            w_stall, w_flush, w_bubble;

  de_pipe_reg_if u_hz_if ();

  // Redirect is ignored in reset; stall is already 0 there since E is a bubble.
  assign u_hz_if.d_valid     = D_valid_i;
  assign u_hz_if.d_rs1       = D_rs1_i;
  assign u_hz_if.d_rs2       = D_rs2_i;
  assign u_hz_if.d_use_rs1   = D_use_rs1_i;
  assign u_hz_if.d_use_rs2   = D_use_rs2_i;
  assign u_hz_if.e_valid     = r_ctrl.valid;
  assign u_hz_if.e_need_dstE = r_ctrl.need_dstE;
  assign u_hz_if.e_sel_reg   = r_ctrl.sel_reg;
  assign u_hz_if.e_dstE      = r_ctrl.dstE;
  assign u_hz_if.redirect    = E_redirect_i && rst_n_i;

  de_hazard u_hazard (.hz(u_hz_if.slave));

  assign w_stall  = u_hz_if.stall;
  assign w_flush  = u_hz_if.flush;
  // An invalid D entry is captured as a full bubble.
  assign w_bubble = w_stall || w_flush || !D_valid_i;

  assign F_stall_o = w_stall;
  assign D_stall_o = w_stall;
  assign D_flush_o = w_flush;

  // E register: bubble on stall/flush/invalid, otherwise capture D.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ctrl <= E_CTRL_BUBBLE;
      r_pc   <= '0;
      r_srcA <= '0;
      r_srcB <= '0;
      r_imm  <= '0;
    end else if (w_bubble) begin
      r_ctrl <= E_CTRL_BUBBLE;
      r_pc   <= '0;
      r_srcA <= '0;
      r_srcB <= '0;
      r_imm  <= '0;
    end else begin
      r_ctrl <= '{valid: 1'b1, need_dstE: D_need_dstE_i, sel_reg: D_sel_reg_i,
                  dstE: D_dstE_i, alu_op: D_alu_op_i};
      r_pc   <= D_pc_i;
      r_srcA <= D_fwdA_i;
      r_srcB <= D_fwdB_i;
      r_imm  <= D_imm_i;
    end
  end

  assign E_valid_o     = r_ctrl.valid;
  assign E_need_dstE_o = r_ctrl.need_dstE;
  assign E_sel_reg_o   = r_ctrl.sel_reg;
  assign E_dstE_o      = r_ctrl.dstE;
  assign E_alu_op_o    = r_ctrl.alu_op;
  assign E_pc_o        = r_pc;
  assign E_srcA_o      = r_srcA;
  assign E_srcB_o      = r_srcB;
  assign E_imm_o       = r_imm;

`ifdef DE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Saturating counts of stall and flush cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, w_stall);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_flush);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: directed table, reset corners, random vs. model.
module tb_de_pipe_reg;
  import de_pipe_reg_pkg::*;

`ifdef DE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  de_pipe_reg_if bus ();

  logic [31:0] d_pc, d_fwdA, d_fwdB, d_imm;
  logic [4:0]  d_dstE;
  logic        d_need, d_sel;
  logic [3:0]  d_op;
  logic [31:0] e_pc, e_srcA, e_srcB, e_imm;
  logic [3:0]  e_op;
  logic        d_stall;
  logic [31:0] stall_cnt, flush_cnt;

  de_pipe_reg #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_valid_i(bus.d_valid), .D_pc_i(d_pc), .D_fwdA_i(d_fwdA), .D_fwdB_i(d_fwdB),
    .D_imm_i(d_imm), .D_rs1_i(bus.d_rs1), .D_rs2_i(bus.d_rs2), .D_dstE_i(d_dstE),
    .D_use_rs1_i(bus.d_use_rs1), .D_use_rs2_i(bus.d_use_rs2),
    .D_need_dstE_i(d_need), .D_sel_reg_i(d_sel), .D_alu_op_i(d_op),
    .E_redirect_i(bus.redirect),
    .E_valid_o(bus.e_valid), .E_pc_o(e_pc), .E_srcA_o(e_srcA), .E_srcB_o(e_srcB),
    .E_imm_o(e_imm), .E_dstE_o(bus.e_dstE), .E_need_dstE_o(bus.e_need_dstE),
    .E_sel_reg_o(bus.e_sel_reg), .E_alu_op_o(e_op),
    .F_stall_o(bus.stall), .D_stall_o(d_stall), .D_flush_o(bus.flush),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what E should hold, and the counters.
  typedef struct {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  dst;
    logic        need, sel;
    logic [3:0]  op;
  } ent_t;

  ent_t        m_e;
  logic [31:0] m_sc, m_fc;

  function automatic ent_t bubble_ent();
    ent_t e;
    e.valid = 0; e.pc = 0; e.a = 0; e.b = 0; e.imm = 0;
    e.dst = 0; e.need = 0; e.sel = 1; e.op = 0;
    return e;
  endfunction

  function automatic logic m_hazard();
    logic rd_hit;
    rd_hit = (bus.d_use_rs1 && bus.d_rs1 == m_e.dst) ||
             (bus.d_use_rs2 && bus.d_rs2 == m_e.dst);
    return m_e.valid && m_e.need && !m_e.sel && bus.d_valid && m_e.dst != 0 && rd_hit;
  endfunction

  task automatic model_reset();
    m_e = bubble_ent(); m_sc = 0; m_fc = 0;
  endtask

  task automatic chk_e(input string tag);
    chk({tag, ".valid"}, bus.e_valid, m_e.valid);
    chk({tag, ".pc"},    e_pc,   m_e.pc);
    chk({tag, ".srcA"},  e_srcA, m_e.a);
    chk({tag, ".srcB"},  e_srcB, m_e.b);
    chk({tag, ".imm"},   e_imm,  m_e.imm);
    chk({tag, ".dst"},   bus.e_dstE, m_e.dst);
    chk({tag, ".need"},  bus.e_need_dstE, m_e.need);
    chk({tag, ".sel"},   bus.e_sel_reg, m_e.sel);
    chk({tag, ".op"},    e_op, m_e.op);
    chk({tag, ".scnt"},  stall_cnt, m_sc);
    chk({tag, ".fcnt"},  flush_cnt, m_fc);
  endtask

  // Inputs already driven: check combinational outputs, clock, check E.
  task automatic model_step(input string tag);
    logic st, fl;
    #1;
    fl = bus.redirect;
    st = m_hazard() && !bus.redirect;
    chk({tag, ".fstall"}, bus.stall, st);
    chk({tag, ".dstall"}, d_stall, st);
    chk({tag, ".flush"},  bus.flush, fl);
    @(posedge clk);
    if (PERF && st && m_sc != 32'hFFFF_FFFF) m_sc++;
    if (PERF && fl && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (st || fl || !bus.d_valid) m_e = bubble_ent();
    else begin
      m_e.valid = 1; m_e.pc = d_pc; m_e.a = d_fwdA; m_e.b = d_fwdB; m_e.imm = d_imm;
      m_e.dst = d_dstE; m_e.need = d_need; m_e.sel = d_sel; m_e.op = d_op;
    end
    #1;
    chk_e(tag);
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  dst;
    logic        need, sel;
    logic [31:0] a, b;
    logic        redir;
    logic        x_stall, x_flush, x_valid;
    logic [4:0]  x_dst;
    logic [31:0] x_a, x_b;
  } vec_t;

  vec_t tbl[10];

  task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] dst,
                         input logic need, input logic sel, input logic [31:0] a,
                         input logic [31:0] b, input logic redir);
    bus.d_valid = v; bus.d_rs1 = rs1; bus.d_rs2 = rs2;
    bus.d_use_rs1 = u1; bus.d_use_rs2 = u2; d_dstE = dst;
    d_need = need; d_sel = sel; d_fwdA = a; d_fwdB = b; bus.redirect = redir;
    d_pc = 0; d_imm = 0; d_op = 0;
  endtask

  initial begin
    //        v  rs1 rs2 u1 u2 dst need sel  a        b        rd  xs xf xv xdst xa        xb
    tbl[0] = '{1, 1,  2,  1, 1, 5,  1,  1,  32'h10,  32'h20,  0,  0, 0, 1, 5,  32'h10,  32'h20};  // add x5
    tbl[1] = '{1, 1,  0,  1, 0, 7,  1,  0,  32'h100, 32'h200, 0,  0, 0, 1, 7,  32'h100, 32'h200}; // lw x7
    tbl[2] = '{1, 3,  7,  1, 1, 8,  1,  1,  32'h33,  32'h77,  0,  1, 0, 0, 0,  32'h0,   32'h0};   // add uses x7: stall
    tbl[3] = '{1, 3,  7,  1, 1, 8,  1,  1,  32'h33,  32'h77,  0,  0, 0, 1, 8,  32'h33,  32'h77};  // add enters E
    tbl[4] = '{1, 8,  0,  1, 0, 0,  1,  0,  32'h44,  32'h0,   0,  0, 0, 1, 0,  32'h44,  32'h0};   // lw x0
    tbl[5] = '{1, 0,  0,  1, 1, 3,  1,  1,  32'h55,  32'h66,  0,  0, 0, 1, 3,  32'h55,  32'h66};  // reads x0: no stall
    tbl[6] = '{1, 2,  0,  1, 0, 9,  1,  0,  32'h99,  32'h0,   0,  0, 0, 1, 9,  32'h99,  32'h0};   // lw x9
    tbl[7] = '{1, 9,  1,  1, 1, 10, 1,  1,  32'hA,   32'hB,   1,  0, 1, 0, 0,  32'h0,   32'h0};   // hazard+redirect
    tbl[8] = '{1, 1,  2,  1, 1, 4,  1,  0,  32'hC,   32'hD,   0,  0, 0, 1, 4,  32'hC,   32'hD};   // lw x4
    tbl[9] = '{0, 4,  4,  1, 1, 6,  1,  1,  32'hE,   32'hF,   0,  0, 0, 0, 0,  32'h0,   32'h0};   // invalid D

    // Reset state, with redirect asserted to show it is ignored.
    rst_n = 1'b0;
    drive_d(1, 1, 1, 1, 1, 1, 1, 0, 32'h1, 32'h2, 1);
    #7;
    chk("rst.valid", bus.e_valid, 0);
    chk("rst.sel",   bus.e_sel_reg, 1);
    chk("rst.dst",   bus.e_dstE, 0);
    chk("rst.srcA",  e_srcA, 0);
    chk("rst.flush", bus.flush, 0);
    chk("rst.stall", bus.stall, 0);
    chk("rst.scnt",  stall_cnt, 0);
    chk("rst.fcnt",  flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      drive_d(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].dst,
              tbl[i].need, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].redir);
      #1;
      chk($sformatf("t%0d.fstall", i), bus.stall, tbl[i].x_stall);
      chk($sformatf("t%0d.dstall", i), d_stall, tbl[i].x_stall);
      chk($sformatf("t%0d.flush", i),  bus.flush, tbl[i].x_flush);
      @(posedge clk); #1;
      chk($sformatf("t%0d.valid", i), bus.e_valid, tbl[i].x_valid);
      chk($sformatf("t%0d.dst", i),   bus.e_dstE, tbl[i].x_dst);
      chk($sformatf("t%0d.srcA", i),  e_srcA, tbl[i].x_a);
      chk($sformatf("t%0d.srcB", i),  e_srcB, tbl[i].x_b);
    end
    chk("tbl.scnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    chk("tbl.fcnt", flush_cnt, PERF ? 32'd1 : 32'd0);

    // Asynchronous reset mid-cycle while E is valid.
    drive_d(1, 0, 0, 0, 0, 6, 1, 1, 32'h1234, 32'h5678, 0);
    @(posedge clk); #1;
    chk("ar.pre_valid", bus.e_valid, 1);
    #2;
    rst_n = 1'b0;
    bus.redirect = 1'b1;
    #1;
    chk("ar.valid", bus.e_valid, 0);
    chk("ar.dst",   bus.e_dstE, 0);
    chk("ar.srcA",  e_srcA, 0);
    chk("ar.sel",   bus.e_sel_reg, 1);
    chk("ar.scnt",  stall_cnt, 0);
    chk("ar.fcnt",  flush_cnt, 0);
    chk("ar.flush", bus.flush, 0);
    @(posedge clk); #1;
    chk("ar.hold_valid", bus.e_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.redirect = 1'b0;
    #1;
    chk("ar.rel_stall", bus.stall, 0);
    @(posedge clk); #1;
    chk("ar.resume_valid", bus.e_valid, 1);
    chk("ar.resume_srcA",  e_srcA, 32'h1234);
    chk("ar.resume_dst",   bus.e_dstE, 6);

    // Random stimulus against the model, after a fresh reset.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bus.d_valid   = ($urandom_range(0, 7) != 0);
      bus.d_rs1     = 5'($urandom_range(0, 3));
      bus.d_rs2     = 5'($urandom_range(0, 3));
      bus.d_use_rs1 = 1'($urandom);
      bus.d_use_rs2 = 1'($urandom);
      d_dstE        = 5'($urandom_range(0, 3));
      d_need        = 1'($urandom);
      d_sel         = 1'($urandom);
      d_op          = 4'($urandom);
      d_pc          = $urandom;
      d_fwdA        = $urandom;
      d_fwdB        = $urandom;
      d_imm         = $urandom;
      bus.redirect  = ($urandom_range(0, 5) == 0);
      model_step($sformatf("r%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
